// File: rtl/radio_ramp_seq.sv
// Radio analog power sequencer: turns radioEnable/radioRxEn level requests into timed
// LDO -> synth -> RX/TX chain enables. Optional macro RADIO_RAMP_SYNC_EN adds 2-flop input synchronizers.
module radio_ramp_seq #(
  parameter int RAMP_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int DOWN_CYCLES   = 4,
  parameter int CNT_W         = 8
) (
  input  logic ck,
  input  logic arst,
  input  logic radioEnable,
  input  logic radioRxEn,
  input  logic isolateM2,
  output logic ldoEn,
  output logic synthEn,
  output logic rxChainEn,
  output logic txChainEn,
  output logic ready,
  output logic busy
);

  localparam logic [CNT_W-1:0] RAMP_LD   = CNT_W'(RAMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOWN_LD   = CNT_W'(DOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    LDO_RAMP,
    SYNTH_SETTLE,
    ACTIVE,
    RAMP_DOWN
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             mode_rx, mode_rx_n;
  logic             req_en, req_rx;
  logic             en, rx;

`ifdef RADIO_RAMP_SYNC_EN
  logic [1:0] req_p0, req_p1;

  // synchronizer stages: {enable, rx}
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      req_p0 <= '0;
      req_p1 <= '0;
    end else begin
      req_p0 <= {radioEnable, radioRxEn};
      req_p1 <= req_p0;
    end
  end

  assign req_en = req_p1[1];
  assign req_rx = req_p1[0];
`else
  assign req_en = radioEnable;
  assign req_rx = radioRxEn;
`endif

  // Isolation clamps are unsynchronized and force both requests off.
  assign en = req_en & ~isolateM2;
  assign rx = req_rx & ~isolateM2;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mode_rx_n = mode_rx;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_n = LDO_RAMP;
          cnt_n   = RAMP_LD;
        end
      end
      LDO_RAMP: begin
        if (!en) begin
          state_n = RAMP_DOWN;
          cnt_n   = DOWN_LD;
        end else if (cnt == '0) begin
          state_n = SYNTH_SETTLE;
          cnt_n   = SETTLE_LD;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      SYNTH_SETTLE: begin
        if (!en) begin
          state_n = RAMP_DOWN;
          cnt_n   = DOWN_LD;
        end else if (cnt == '0) begin
          state_n   = ACTIVE;
          mode_rx_n = rx;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      ACTIVE: begin
        // Power-down wins over an RX/TX turnaround request.
        if (!en) begin
          state_n = RAMP_DOWN;
          cnt_n   = DOWN_LD;
        end else if (rx != mode_rx) begin
          state_n = SYNTH_SETTLE;
          cnt_n   = SETTLE_LD;
        end
      end
      RAMP_DOWN: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CNT_ONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register together with it.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_rx   <= 1'b0;
      ldoEn     <= 1'b0;
      synthEn   <= 1'b0;
      rxChainEn <= 1'b0;
      txChainEn <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mode_rx   <= mode_rx_n;
      ldoEn     <= (state_n != IDLE);
      synthEn   <= (state_n == SYNTH_SETTLE) || (state_n == ACTIVE);
      rxChainEn <= (state_n == ACTIVE) &&  mode_rx_n;
      txChainEn <= (state_n == ACTIVE) && !mode_rx_n;
      ready     <= (state_n == ACTIVE);
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_radio_ramp_seq.sv
// Self-checking bench for radio_ramp_seq: directed power-sequence steps followed by randomized
// request traffic, all compared against an elapsed-time reference model.
module tb_radio_ramp_seq;

  localparam int RAMP   = 16;
  localparam int SETTLE = 8;
  localparam int DOWN   = 4;
`ifdef RADIO_RAMP_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic ck = 1'b0;
  logic arst = 1'b1;
  logic radioEnable = 1'b0;
  logic radioRxEn = 1'b0;
  logic isolateM2 = 1'b0;
  logic ldoEn, synthEn, rxChainEn, txChainEn, ready, busy;

  radio_ramp_seq #(
    .RAMP_CYCLES(RAMP), .SETTLE_CYCLES(SETTLE), .DOWN_CYCLES(DOWN), .CNT_W(8)
  ) dut (
    .ck(ck), .arst(arst), .radioEnable(radioEnable), .radioRxEn(radioRxEn),
    .isolateM2(isolateM2), .ldoEn(ldoEn), .synthEn(synthEn), .rxChainEn(rxChainEn),
    .txChainEn(txChainEn), .ready(ready), .busy(busy)
  );

  always #5 ck = ~ck;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Reference model: ages measured in edges since power-up / since synth came on.
  int up_age   = 0;
  int syn_age  = 0;
  int down_rem = 0;
  bit mode     = 1'b0;
  bit dq_en[2];
  bit dq_rx[2];

  task automatic model_reset();
    up_age = 0; syn_age = 0; down_rem = 0; mode = 1'b0;
    dq_en[0] = 0; dq_en[1] = 0; dq_rx[0] = 0; dq_rx[1] = 0;
  endtask

  task automatic model_edge();
    bit en, rx;
    if (arst) begin
      model_reset();
      return;
    end
`ifdef RADIO_RAMP_SYNC_EN
    en = dq_en[1] & ~isolateM2;
    rx = dq_rx[1] & ~isolateM2;
    dq_en[1] = dq_en[0]; dq_en[0] = radioEnable;
    dq_rx[1] = dq_rx[0]; dq_rx[0] = radioRxEn;
`else
    en = radioEnable & ~isolateM2;
    rx = radioRxEn & ~isolateM2;
`endif
    if (down_rem > 0) begin
      down_rem--;
    end else if (up_age == 0) begin
      if (en) up_age = 1;
    end else if (!en) begin
      up_age = 0; syn_age = 0; down_rem = DOWN;
    end else if (up_age <= RAMP) begin
      up_age++;
      if (up_age == RAMP + 1) syn_age = 0;
    end else if (syn_age >= SETTLE) begin
      if (rx != mode) syn_age = 0;
    end else begin
      syn_age++;
      if (syn_age == SETTLE) mode = rx;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_model();
    bit e_ldo, e_syn, e_rdy;
    e_ldo = (up_age > 0) || (down_rem > 0);
    e_syn = (up_age > RAMP) && (down_rem == 0);
    e_rdy = e_syn && (syn_age >= SETTLE);
    chk("m_ldoEn", ldoEn, e_ldo);
    chk("m_synthEn", synthEn, e_syn);
    chk("m_ready", ready, e_rdy);
    chk("m_rxChainEn", rxChainEn, e_rdy & mode);
    chk("m_txChainEn", txChainEn, e_rdy & ~mode);
    chk("m_busy", busy, e_ldo);
  endtask

  task automatic tick();
    @(posedge ck);
    model_edge();
    edge_n++;
    @(negedge ck);
    check_model();
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ldo"}, ldoEn, 1'b0);
    chk({tag, "_synth"}, synthEn, 1'b0);
    chk({tag, "_rx"}, rxChainEn, 1'b0);
    chk({tag, "_tx"}, txChainEn, 1'b0);
    chk({tag, "_ready"}, ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int e, n0;
    model_reset();
    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    arst = 1'b0;
    edge_n = 0;

    // Test 1: power-up into RX
    run_to(9);
    radioEnable = 1'b1; radioRxEn = 1'b1;
    run_to(10 + LAT);                 chk("t1_ldo_on", ldoEn, 1'b1);
    run_to(25 + LAT);                 chk("t1_synth_early", synthEn, 1'b0);
    run_to(26 + LAT);                 chk("t1_synth_on", synthEn, 1'b1);
    run_to(33 + LAT);                 chk("t1_ready_early", ready, 1'b0);
    run_to(34 + LAT);                 chk("t1_ready_on", ready, 1'b1);
    chk("t1_rx_on", rxChainEn, 1'b1);

    // Test 2: RX -> TX turnaround
    run_to(49);
    radioRxEn = 1'b0;
    run_to(50 + LAT);
    chk("t2_rx_off", rxChainEn, 1'b0);
    chk("t2_ready_off", ready, 1'b0);
    chk("t2_synth_kept", synthEn, 1'b1);
    run_to(57 + LAT);                 chk("t2_tx_early", txChainEn, 1'b0);
    run_to(58 + LAT);                 chk("t2_tx_on", txChainEn, 1'b1);
    chk("t2_ready_on", ready, 1'b1);

    // Test 3: power-down from ACTIVE
    run_to(69);
    radioEnable = 1'b0;
    run_to(70 + LAT);
    chk("t3_synth_off", synthEn, 1'b0);
    chk("t3_tx_off", txChainEn, 1'b0);
    run_to(73 + LAT);                 chk("t3_ldo_hold", ldoEn, 1'b1);
    run_to(74 + LAT);                 chk("t3_ldo_off", ldoEn, 1'b0);
    chk("t3_busy_off", busy, 1'b0);

    // Test 4: isolation during LDO ramp with cnt=5
    run_to(80);
    radioEnable = 1'b1; radioRxEn = 1'b1;
    n0 = 81 + LAT;
    run_to(n0 + 10);
    isolateM2 = 1'b1;
    run_to(n0 + 11);
    chk("t4_ldo_down", ldoEn, 1'b1);
    chk("t4_synth_never", synthEn, 1'b0);
    run_to(n0 + 14);                  chk("t4_ldo_hold", ldoEn, 1'b1);
    run_to(n0 + 15);                  chk("t4_idle", busy, 1'b0);
    run_to(n0 + 20);
    isolateM2 = 1'b0;
    run_to(n0 + 60);
    chk("t4_reactive", ready, 1'b1);

    // Test 5: re-request during ramp-down gives a 1-cycle ldo gap
    e = edge_n;
    radioEnable = 1'b0;
    tick();
    radioEnable = 1'b1;
    run_to(e + 4 + LAT);              chk("t5_ldo_hold", ldoEn, 1'b1);
    run_to(e + 5 + LAT);              chk("t5_ldo_gap", ldoEn, 1'b0);
    run_to(e + 6 + LAT);              chk("t5_ldo_restart", ldoEn, 1'b1);

    // Test 6: async reset in SYNTH_SETTLE, then full power-up again
    run_to(e + 6 + LAT + RAMP + 2);
    chk("t6_in_settle", synthEn, 1'b1);
    arst = 1'b1;
    #1;
    check_all_zero("t6_async");
    model_reset();
    #1 arst = 1'b0;
    edge_n = 0;
    run_to(1 + LAT);                  chk("t6_ldo_on", ldoEn, 1'b1);
    run_to(1 + LAT + RAMP);           chk("t6_synth_on", synthEn, 1'b1);
    run_to(1 + LAT + RAMP + SETTLE - 1); chk("t6_ready_early", ready, 1'b0);
    run_to(1 + LAT + RAMP + SETTLE);  chk("t6_ready_on", ready, 1'b1);
    chk("t6_rx_on", rxChainEn, 1'b1);

    // Randomized request traffic
    for (int s = 0; s < 80; s++) begin
      radioEnable = ($urandom_range(0, 9) < 8);
      radioRxEn   = $urandom_range(0, 1);
      isolateM2   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) begin
        arst = 1'b1;
        #1;
        check_all_zero("rnd_async");
        model_reset();
        #1 arst = 1'b0;
      end
      repeat ($urandom_range(1, 40)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
